ppu_sprite_eval_fsm: RTL

//  Per-scanline sprite evaluator: scans all 64 OAM entries from cpu_sprite_addr, caches up to
//  MAX_SPRITES sprites intersecting curr_row (8- or 16-line sprites), then each cycle presents the

---
 rtl/ppu_sprite_pkg.sv | 31 +++
 rtl/ppu_sprite_tile_select.sv | 81 ++++++++
 rtl/ppu_sprite_eval_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ppu_sprite_pkg.sv
// ppu_sprite_pkg: shared types and constants for the per-scanline sprite
// evaluator.
//   state_t       evaluator FSM states
//   sprite_ent_t  one cached sprite (OAM Y, tile, attr, X) plus valid
//   tile_overlap  true when a sprite X falls within +/-7 pixels of the
//                 tile's left column (col is two's complement)
package ppu_sprite_pkg;
  localparam int OAM_ENTRIES = 64;
  localparam int TILE_W      = 8;
  localparam int H_SMALL     = 8;
  localparam int H_LARGE     = 16;

  typedef enum logic [2:0] {IDLE, ADDR, CHECK, LOAD, DONE} state_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
    logic       valid;
  } sprite_ent_t;

  localparam logic signed [9:0] TILE_W_S = 10'(TILE_W);

  // 10-bit signed keeps X in [0,255] minus col in [-256,255] from wrapping.
  function automatic logic tile_overlap(input logic [7:0] x, input logic [8:0] col);
    logic signed [9:0] d;
    d = $signed({2'b00, x}) - $signed({col[8], col});
    return (d > -TILE_W_S) && (d < TILE_W_S);
  endfunction
endpackage

// File: rtl/ppu_sprite_tile_select.sv
// ppu_sprite_tile_select: picks the first NUM_OUT valid cached sprites that
// overlap the tile at curr_col (slot order == OAM order) and registers them.
// Ports:
//   clk, rst            clock, async active-low reset
//   slots               cached sprite array
//   curr_col            tile left pixel, two's complement
//   spr_on_tile         per-channel valid
//   spr_tile_num/row/col/attr  channel k at [8k+:8]; zero when channel unused
// Optional (PPU_SPRITE_ZERO_HIT_EN): slot_zero in, spr_is_zero out.
module ppu_sprite_tile_select
  import ppu_sprite_pkg::*;
#(
  parameter int MAX_SPRITES = 8,
  parameter int NUM_OUT     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  sprite_ent_t [MAX_SPRITES-1:0]     slots,
  input  logic [8:0]                        curr_col,
  output logic [NUM_OUT-1:0]                spr_on_tile,
  output logic [8*NUM_OUT-1:0]              spr_tile_num,
  output logic [8*NUM_OUT-1:0]              spr_row,
  output logic [8*NUM_OUT-1:0]              spr_col,
  output logic [8*NUM_OUT-1:0]              spr_attr
`ifdef PPU_SPRITE_ZERO_HIT_EN
  ,
  input  logic [MAX_SPRITES-1:0]            slot_zero,
  output logic [NUM_OUT-1:0]                spr_is_zero
`endif
);

  logic [MAX_SPRITES-1:0] hit;
  logic [7:0]             rank [MAX_SPRITES];

  // rank[i] = number of hitting slots below i; a hit with rank k drives channel k.
  always_comb begin
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      hit[i]  = slots[i].valid && tile_overlap(slots[i].x, curr_col);
      rank[i] = n;
      if (hit[i]) n = n + 8'd1;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    sprite_ent_t sel, ch_q;

    always_comb begin
      sel = '0;
      for (int i = 0; i < MAX_SPRITES; i++)
        if (hit[i] && rank[i] == 8'(k)) sel = slots[i];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) ch_q <= '0;
      else      ch_q <= sel;
    end

    assign spr_on_tile[k]        = ch_q.valid;
    assign spr_tile_num[8*k +: 8] = ch_q.tile;
    assign spr_row[8*k +: 8]      = ch_q.y;
    assign spr_col[8*k +: 8]      = ch_q.x;
    assign spr_attr[8*k +: 8]     = ch_q.attr;

`ifdef PPU_SPRITE_ZERO_HIT_EN
    logic zsel, z_q;
    always_comb begin
      zsel = 1'b0;
      for (int i = 0; i < MAX_SPRITES; i++)
        if (hit[i] && rank[i] == 8'(k)) zsel = slot_zero[i];
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) z_q <= 1'b0;
      else      z_q <= zsel;
    end
    assign spr_is_zero[k] = z_q;
`endif
  end

endmodule

// File: rtl/ppu_sprite_eval_fsm.sv
// ppu_sprite_eval_fsm: per-scanline sprite evaluator. Scans 64 OAM entries
// starting at cpu_sprite_addr (wrapping), caches up to MAX_SPRITES sprites
// covering curr_row, and each cycle presents the first NUM_OUT cached sprites
// overlapping the tile at curr_col.
// Ports:
//   clk, rst            clock, async active-low reset
//   spram_addr          sprite RAM address (data returns next cycle)
//   spram_data_in       sprite RAM read data
//   curr_row, curr_col  scanline (unsigned), tile column (two's complement)
//   sprite_size_16      8x16 mode, sampled on start
//   start, cpu_sprite_addr  kick off a scan from this byte address
//   busy, done          scan in progress / one-cycle completion pulse
//   sprite_overflow     more in-range sprites than slots; held until next start
//   spr_*               NUM_OUT registered sprite channels
// Optional feature macro PPU_SPRITE_ZERO_HIT_EN adds spr_is_zero.
module ppu_sprite_eval_fsm
  import ppu_sprite_pkg::*;
#(
  parameter int MAX_SPRITES = 8,
  parameter int NUM_OUT     = 2,
  parameter int OAM_AW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [OAM_AW-1:0]    spram_addr,
  input  logic [7:0]           spram_data_in,
  input  logic [8:0]           curr_row,
  input  logic [8:0]           curr_col,
  input  logic                 sprite_size_16,
  input  logic                 start,
  input  logic [7:0]           cpu_sprite_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 sprite_overflow,
  output logic [NUM_OUT-1:0]   spr_on_tile,
  output logic [8*NUM_OUT-1:0] spr_tile_num,
  output logic [8*NUM_OUT-1:0] spr_row,
  output logic [8*NUM_OUT-1:0] spr_col,
  output logic [8*NUM_OUT-1:0] spr_attr
`ifdef PPU_SPRITE_ZERO_HIT_EN
  ,
  output logic [NUM_OUT-1:0]   spr_is_zero
`endif
);

  localparam int CNT_W = $clog2(MAX_SPRITES + 1);
  localparam int ENT_W = $clog2(OAM_ENTRIES);

  state_t                        state, nxt;
  logic [1:0]                    ld_cnt;
  logic [ENT_W-1:0]              entry;
  logic [CNT_W-1:0]              count;
  logic                          h16;
  sprite_ent_t [MAX_SPRITES-1:0] slots;
  logic                          in_range, full, last_ent;

  // 9-bit wrap makes Y > row a huge difference, so one compare covers both ends.
  assign in_range = (curr_row - {1'b0, spram_data_in}) < (h16 ? 9'(H_LARGE) : 9'(H_SMALL));
  assign full     = count == CNT_W'(MAX_SPRITES);
  assign last_ent = entry == ENT_W'(OAM_ENTRIES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = ADDR;
      ADDR:    nxt = CHECK;
      CHECK:   if (!in_range) nxt = last_ent ? DONE : ADDR;
               else           nxt = full ? DONE : LOAD;
      LOAD:    if (ld_cnt == 2'd2) nxt = last_ent ? DONE : ADDR;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end

  // Address walk per entry: ADDR b, CHECK b+1, LOAD b+2/b+3/b+4, next ADDR b+4.
  // A miss in CHECK jumps b+1 -> b+4 directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spram_addr      <= '0;
      ld_cnt          <= '0;
      entry           <= '0;
      count           <= '0;
      h16             <= 1'b0;
      sprite_overflow <= 1'b0;
      slots           <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          spram_addr      <= OAM_AW'(cpu_sprite_addr);
          h16             <= sprite_size_16;
          count           <= '0;
          entry           <= '0;
          ld_cnt          <= '0;
          sprite_overflow <= 1'b0;
          for (int i = 0; i < MAX_SPRITES; i++) slots[i].valid <= 1'b0;
        end
        ADDR: spram_addr <= spram_addr + OAM_AW'(1);
        CHECK: begin
          if (!in_range) begin
            spram_addr <= spram_addr + OAM_AW'(3);
            entry      <= entry + ENT_W'(1);
          end else if (full) begin
            sprite_overflow <= 1'b1;
          end else begin
            spram_addr <= spram_addr + OAM_AW'(1);
            ld_cnt     <= '0;
            for (int i = 0; i < MAX_SPRITES; i++)
              if (CNT_W'(i) == count) slots[i].y <= spram_data_in;
          end
        end
        LOAD: begin
          ld_cnt <= ld_cnt + 2'd1;
          if (ld_cnt != 2'd2) spram_addr <= spram_addr + OAM_AW'(1);
          for (int i = 0; i < MAX_SPRITES; i++) begin
            if (CNT_W'(i) == count) begin
              case (ld_cnt)
                2'd0:    slots[i].tile <= spram_data_in;
                2'd1:    slots[i].attr <= spram_data_in;
                default: begin
                  slots[i].x     <= spram_data_in;
                  slots[i].valid <= 1'b1;
                end
              endcase
            end
          end
          if (ld_cnt == 2'd2) begin
            count <= count + CNT_W'(1);
            entry <= entry + ENT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PPU_SPRITE_ZERO_HIT_EN
  // In CHECK the address is already base+1, so base 0x00 shows up as 1.
  logic [MAX_SPRITES-1:0] slot_zero;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) slot_zero <= '0;
    else if (state == IDLE && start) slot_zero <= '0;
    else if (state == CHECK && in_range && !full)
      for (int i = 0; i < MAX_SPRITES; i++)
        if (CNT_W'(i) == count) slot_zero[i] <= spram_addr == OAM_AW'(1);
  end
`endif

  ppu_sprite_tile_select #(
    .MAX_SPRITES (MAX_SPRITES),
    .NUM_OUT     (NUM_OUT)
  ) u_sel (
    .clk          (clk),
    .rst          (rst),
    .slots        (slots),
    .curr_col     (curr_col),
    .spr_on_tile  (spr_on_tile),
    .spr_tile_num (spr_tile_num),
    .spr_row      (spr_row),
    .spr_col      (spr_col),
    .spr_attr     (spr_attr)
`ifdef PPU_SPRITE_ZERO_HIT_EN
    ,
    .slot_zero    (slot_zero),
    .spr_is_zero  (spr_is_zero)
`endif
  );

endmodule
